// File: rtl/alu_issue_stage.sv
// Operand-fetch / issue / writeback stage wrapped around datapath_core, with an 8-entry register file.
// Optional feature: define ALU_ISSUE_OVERLAP_EN to accept during WB with a writeback bypass.
module alu_issue_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [2:0]       in_rd,
  input  logic [2:0]       in_rs1,
  input  logic [2:0]       in_rs2,
  input  logic             in_imm_sel,
  input  logic [WIDTH-1:0] in_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  output logic             wb_valid,
  output logic [2:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic [3:0]       flags_q,
  output logic             err_illegal,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_rf [0:7];
  logic [3:0]         r_op_p0;
  logic [2:0]         r_rd_p0;
  logic [WIDTH-1:0]   r_opa_p0;
  logic [WIDTH-1:0]   r_opb_p0;
  logic [WIDTH-1:0]   r_wb_data_p1;
  logic [2:0]         r_wb_rd_p1;
  logic [3:0]         r_flags_hold_p1;
  logic               r_illegal_p1;
  logic [3:0]         r_flags_q;

  logic               w_accept;
  logic               w_wb_legal;
  logic [WIDTH-1:0]   w_rs1_val;
  logic [WIDTH-1:0]   w_rs2_val;
  logic [WIDTH-1:0]   w_opa;
  logic [WIDTH-1:0]   w_opb;

  assign w_wb_legal = (r_state == S_WB) && !r_illegal_p1;

`ifdef ALU_ISSUE_OVERLAP_EN
  logic w_byp_ok;

  assign in_ready  = (r_state == S_IDLE) || (r_state == S_WB);
  // The write of the instruction in WB lands on the same edge as this read, so forward it.
  assign w_byp_ok  = w_wb_legal && (r_wb_rd_p1 != 3'd0);
  assign w_rs1_val = (w_byp_ok && (in_rs1 == r_wb_rd_p1)) ? r_wb_data_p1 :
                     (in_rs1 == 3'd0) ? '0 : r_rf[in_rs1];
  assign w_rs2_val = (w_byp_ok && (in_rs2 == r_wb_rd_p1)) ? r_wb_data_p1 :
                     (in_rs2 == 3'd0) ? '0 : r_rf[in_rs2];
`else
  assign in_ready  = (r_state == S_IDLE);
  assign w_rs1_val = (in_rs1 == 3'd0) ? '0 : r_rf[in_rs1];
  assign w_rs2_val = (in_rs2 == 3'd0) ? '0 : r_rf[in_rs2];
`endif

  assign w_accept = in_valid && in_ready;
  assign w_opa    = w_rs1_val;
  assign w_opb    = in_imm_sel ? in_imm : w_rs2_val;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_WB;
      S_WB:    w_state_nxt = w_accept ? S_EXEC : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_op_p0         <= '0;
      r_rd_p0         <= '0;
      r_opa_p0        <= '0;
      r_opb_p0        <= '0;
      r_wb_data_p1    <= '0;
      r_wb_rd_p1      <= '0;
      r_flags_hold_p1 <= '0;
      r_illegal_p1    <= 1'b0;
      r_flags_q       <= '0;
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      // p0: issue -- operands held stable on the datapath_core inputs until the next accept
      if (w_accept) begin
        r_op_p0  <= in_op;
        r_rd_p0  <= in_rd;
        r_opa_p0 <= w_opa;
        r_opb_p0 <= w_opb;
      end
      // p1: capture datapath_core result at the end of EXEC
      if (r_state == S_EXEC) begin
        r_wb_data_p1    <= alu_result;
        r_wb_rd_p1      <= r_rd_p0;
        r_flags_hold_p1 <= {alu_zero, alu_neg, alu_carry, alu_ovf};
        r_illegal_p1    <= r_op_p0[3];
      end
      // commit: architectural state changes only for legal instructions
      if (w_wb_legal) begin
        r_flags_q <= r_flags_hold_p1;
        if (r_wb_rd_p1 != 3'd0) r_rf[r_wb_rd_p1] <= r_wb_data_p1;
      end
    end
  end

  assign alu_a       = r_opa_p0;
  assign alu_b       = r_opb_p0;
  assign alu_op      = r_op_p0;
  assign wb_valid    = w_wb_legal;
  assign err_illegal = (r_state == S_WB) && r_illegal_p1;
  assign wb_rd       = r_wb_rd_p1;
  assign wb_data     = r_wb_data_p1;
  assign flags_q     = r_flags_q;
  assign dbg_data    = (dbg_addr == 3'd0) ? '0 : r_rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: datapath_core stand-in, program-order reference model, per-cycle compare.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_OVERLAP_EN
  localparam int SPACING = 2;
`else
  localparam int SPACING = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [2:0] in_rd, in_rs1, in_rs2;
  logic       in_imm_sel;
  logic [7:0] in_imm;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_zero, alu_neg, alu_carry, alu_ovf;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic [3:0] flags_q;
  logic       err_illegal;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm_sel(in_imm_sel), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flags_q(flags_q),
    .err_illegal(err_illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  typedef struct packed {logic [7:0] r; logic [3:0] f;} alu_t;
  typedef struct packed {logic illegal; logic [2:0] rd; logic [7:0] data; logic [3:0] flags;} exp_t;

  // Behavioural datapath_core: flags {Z,N,C,V}; C is carry for ADD and borrow for SUB.
  function automatic alu_t alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    alu_t o;
    logic [8:0] s;
    logic c, v;
    c = 1'b0; v = 1'b0; s = '0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; o.r = s[7:0]; c = s[8];
                  v = (a[7] == b[7]) && (o.r[7] != a[7]); end
      4'd1: begin o.r = a - b; c = (a < b); v = (a[7] != b[7]) && (o.r[7] != a[7]); end
      4'd2: o.r = a & b;
      4'd3: o.r = a | b;
      4'd4: o.r = a ^ b;
      4'd5: o.r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      4'd6: o.r = a << b[2:0];
      4'd7: o.r = a >> b[2:0];
      default: o.r = 8'hEE;
    endcase
    o.f = {(o.r == 8'd0), o.r[7], c, v};
    return o;
  endfunction

  alu_t dp;
  always_comb dp = alu_ref(alu_op, alu_a, alu_b);
  assign alu_result = dp.r;
  assign alu_zero   = dp.f[3];
  assign alu_neg    = dp.f[2];
  assign alu_carry  = dp.f[1];
  assign alu_ovf    = dp.f[0];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  exp_t q[$];
  exp_t e;
  logic [7:0] spec_rf [8];
  logic [7:0] arch_rf [8];
  logic [3:0] arch_flags;
  logic       dbg_hold;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Per-cycle compare against the architectural model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_err_illegal", err_illegal, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_flags_q", flags_q, 0);
      q.delete();
      for (int i = 0; i < 8; i++) arch_rf[i] = 8'd0;
      arch_flags = 4'd0;
    end else begin
      chk("dbg_data", dbg_data, arch_rf[dbg_addr]);
      chk("flags_q", flags_q, arch_flags);
      if (wb_valid || err_illegal) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: wb_valid=%0b err_illegal=%0b with nothing outstanding",
                   wb_valid, err_illegal);
        end else begin
          e = q.pop_front();
          chk("err_illegal", err_illegal, e.illegal);
          chk("wb_valid", wb_valid, !e.illegal);
          if (!e.illegal) begin
            chk("wb_rd", wb_rd, e.rd);
            chk("wb_data", wb_data, e.data);
            arch_flags = e.flags;
            if (e.rd != 3'd0) arch_rf[e.rd] = e.data;
          end
        end
      end
    end
  end

  initial begin
    dbg_addr = 3'd0;
    forever begin
      @(posedge clk);
      #2;
      if (!dbg_hold) dbg_addr = dbg_addr + 3'd1;
    end
  end

  // Offer an instruction and leave in_valid high; returns the accept cycle.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic isel, input logic [7:0] imm,
                       output int acc);
    exp_t x;
    logic [7:0] a, b;
    alu_t r;
    int n;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm_sel = isel; in_imm = imm;
    in_valid = 1'b1;
    acc = -1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
      n++;
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL accept_timeout: op=%0d not accepted within 20 cycles", op);
      in_valid = 1'b0;
    end else begin
      a = (rs1 == 3'd0) ? 8'd0 : spec_rf[rs1];
      b = isel ? imm : ((rs2 == 3'd0) ? 8'd0 : spec_rf[rs2]);
      r = alu_ref(op, a, b);
      x.illegal = op[3]; x.rd = rd; x.data = r.r; x.flags = r.f;
      q.push_back(x);
      if (!op[3] && rd != 3'd0) spec_rf[rd] = r.r;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dbg_lit(input string name, input logic [2:0] addr, input logic [7:0] req);
    dbg_hold = 1'b1;
    dbg_addr = addr;
    #1;
    chk(name, dbg_data, req);
    dbg_hold = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int acc [5];
  int tmp;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm_sel = 1'b0; in_imm = '0; dbg_hold = 1'b0;
    for (int i = 0; i < 8; i++) spec_rf[i] = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_flags_q", flags_q, 0);
    rst_n = 1'b1;

    issue(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'd5, tmp);
    issue(4'd0, 3'd2, 3'd1, 3'd0, 1'b1, 8'd3, tmp);
    idle(4);
    dbg_lit("lit_r2_is_8", 3'd2, 8'd8);
    chk("lit_flags_add", flags_q, 4'b0000);
    chk("lit_hold_alu_a", alu_a, 8'd5);
    chk("lit_hold_alu_b", alu_b, 8'd3);
    chk("lit_hold_alu_op", alu_op, 4'd0);

    issue(4'd1, 3'd3, 3'd1, 3'd2, 1'b0, 8'd0, tmp);
    idle(4);
    chk("lit_flags_sub", flags_q, 4'b0110);
    dbg_lit("lit_r3_is_fd", 3'd3, 8'hFD);
    issue(4'd5, 3'd4, 3'd3, 3'd1, 1'b0, 8'd0, tmp);
    idle(4);
    dbg_lit("lit_r4_slt", 3'd4, 8'd1);

    issue(4'd0, 3'd5, 3'd0, 3'd0, 1'b1, 8'h7F, tmp);
    issue(4'd0, 3'd0, 3'd5, 3'd0, 1'b1, 8'h01, tmp);
    idle(4);
    chk("lit_flags_ovf", flags_q, 4'b0101);
    dbg_lit("lit_r0_zero", 3'd0, 8'd0);

    issue(4'd9, 3'd7, 3'd1, 3'd2, 1'b0, 8'd0, tmp);
    idle(4);
    chk("lit_flags_after_illegal", flags_q, 4'b0101);
    dbg_lit("lit_r7_untouched", 3'd7, 8'd0);

    issue(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'd0, acc[0]);
    for (int i = 1; i < 5; i++) issue(4'd0, 3'd1, 3'd1, 3'd0, 1'b1, 8'd1, acc[i]);
    idle(4);
    for (int i = 1; i < 5; i++) chk("accept_spacing", acc[i] - acc[i-1], SPACING);
    dbg_lit("lit_chain_r1", 3'd1, 8'd4);

    issue(4'd2, 3'd7, 3'd3, 3'd0, 1'b1, 8'h0F, tmp);
    issue(4'd3, 3'd7, 3'd2, 3'd1, 1'b0, 8'd0, tmp);
    issue(4'd4, 3'd7, 3'd7, 3'd0, 1'b1, 8'hFF, tmp);
    issue(4'd6, 3'd7, 3'd1, 3'd0, 1'b1, 8'd2, tmp);
    issue(4'd7, 3'd7, 3'd3, 3'd1, 1'b0, 8'd0, tmp);
    issue(4'd0, 3'd2, 3'd7, 3'd7, 1'b0, 8'd0, tmp);
    idle(4);
    dbg_lit("lit_r7_srl", 3'd7, 8'h0F);
    dbg_lit("lit_r2_rs2_dep", 3'd2, 8'h1E);

    issue(4'd0, 3'd6, 3'd0, 3'd0, 1'b1, 8'h11, tmp);
    idle(4);
    dbg_lit("lit_r6_pre", 3'd6, 8'h11);
    issue(4'd0, 3'd6, 3'd0, 3'd0, 1'b1, 8'h22, tmp);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) spec_rf[i] = 8'd0;
    #1;
    chk("midrst_alu_b", alu_b, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_wb_valid", wb_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_wb_data", wb_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    dbg_lit("lit_r6_after_rst", 3'd6, 8'd0);
    chk("lit_flags_after_rst", flags_q, 0);
    chk("in_ready_after_rst", in_ready, 1);
    chk("nothing_outstanding", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
